// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction prefetch queue.
//   NOP_INST      : instruction shown to decode when the queue is empty
//   fetch_state_e : fetch control states (IDLE / WAIT / DROP)
//   fetch_entry_t : one queued fetch result (pc, instruction, pc + 4)
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // IDLE: nothing in flight
    // WAIT: fetch in flight, its data will be queued
    // DROP: fetch in flight, its data will be discarded (a redirect overtook it)
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pcinc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// ---------------------------------------------------------------------------
// fetch_queue_if
// Bundles the instruction-memory handshake, the redirect input and the
// decode-side outputs of the prefetch queue.
//   imem_req / imem_addr    : fetch request and address (queue -> memory)
//   imem_ack / imem_rdata   : one-cycle acknowledge with data (memory -> queue)
//   redirect / redirect_pc  : taken branch / jump target from execute
//   de_ready                : decode accepts the head entry
//   de_valid / de_inst / de_pc / de_pcinc : head entry presented to decode
// Modports: master = prefetch queue side, slave = memory/pipeline side.
// ---------------------------------------------------------------------------
interface fetch_queue_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        de_ready;
    logic        de_valid;
    logic [31:0] de_inst;
    logic [31:0] de_pc;
    logic [31:0] de_pcinc;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  redirect, redirect_pc,
        input  de_ready,
        output de_valid, de_inst, de_pc, de_pcinc
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output redirect, redirect_pc,
        output de_ready,
        input  de_valid, de_inst, de_pc, de_pcinc
    );

endinterface

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO of fetch_entry_t with flush.
//   clk, rst_n    : clock, asynchronous active-low reset
//   push_i        : write push_data_i at the tail
//   pop_i         : drop the head entry (caller guarantees non-empty)
//   flush_i       : empty the FIFO; wins over push and pop
//   push_data_i   : entry to write
//   head_o        : current head entry (undefined contents when empty)
//   count_o       : number of valid entries, 0..DEPTH
// ---------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  fetch_entry_t     push_data_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o
);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    fetch_entry_t     mem_q [DEPTH];

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
            else if (pop_i && !push_i) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; count_q alone says which slots are valid,
    // and leaving the array unreset lets it map onto plain flops/LUT-RAM.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Instruction prefetch stage. Owns the fetch PC, issues one word fetch at a
// time to instruction memory, queues returned words with their PC and PC + 4,
// and presents the head entry to decode. A redirect flushes the queue and
// forces any in-flight fetch to be discarded when it returns.
//   clk, rst_n : clock, asynchronous active-low reset
//   fq         : fetch_queue_if.master (memory handshake, redirect, decode side)
// Parameters:
//   DEPTH      : queue entries, power of two, >= 2
//   RESET_PC   : first fetch address after reset
// ---------------------------------------------------------------------------
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_queue_if.master fq
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_e     state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      imem_addr_q, imem_addr_d;
    logic             push;
    logic             pop;
    logic             de_valid;
    logic [CNT_W-1:0] count;
    fetch_entry_t     head;
    fetch_entry_t     push_entry;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        imem_addr_d = imem_addr_q;
        push        = 1'b0;

        unique case (state_q)
            IDLE: begin
                // At most one fetch in flight and a free slot required, so a
                // returning word always has room.
                if (!fq.redirect && (count < CNT_W'(DEPTH))) begin
                    imem_addr_d = fetch_pc_q;
                    fetch_pc_d  = fetch_pc_q + 32'd4;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (fq.imem_ack) begin
                    // A redirect in the ack cycle makes this word stale.
                    push    = !fq.redirect;
                    state_d = IDLE;
                end else if (fq.redirect) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                // The request stays up until memory answers; the answer is dropped.
                if (fq.imem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Redirect overrides any increment above.
        if (fq.redirect) fetch_pc_d = fq.redirect_pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            imem_addr_q <= RESET_PC;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            imem_addr_q <= imem_addr_d;
        end
    end

    assign push_entry = '{pc: imem_addr_q, inst: fq.imem_rdata, pcinc: imem_addr_q + 32'd4};
    assign de_valid   = (count != '0);
    assign pop        = de_valid && fq.de_ready && !fq.redirect;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .pop_i       (pop),
        .flush_i     (fq.redirect),
        .push_data_i (push_entry),
        .head_o      (head),
        .count_o     (count)
    );

    assign fq.imem_req  = (state_q != IDLE);
    assign fq.imem_addr = imem_addr_q;
    assign fq.de_valid  = de_valid;
    assign fq.de_inst   = de_valid ? head.inst  : NOP_INST;
    assign fq.de_pc     = de_valid ? head.pc    : 32'h0;
    assign fq.de_pcinc  = de_valid ? head.pcinc : 32'h0;

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch stage in front of the decode pipeline register. Owns the fetch PC and issues word fetches to instruction memory over a request/acknowledge handshake. Buffers returned instructions with their PC and PC+4 in a small FIFO, and presents the head entry to decode. Branch redirects from the execute stage flush the buffer and any in-flight fetch.

## Interface

Parameters:
- DEPTH, 4: queue entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request, held until acknowledged.
- imem_addr  out  32  fetch address, stable while imem_req is 1.
- imem_ack  in  1  one-cycle pulse; imem_rdata is valid in that cycle.
- imem_rdata  in  32  returned instruction word.
- redirect  in  1  taken branch or jump (execute-stage NextPcSrc).
- redirect_pc  in  32  redirect target (execute-stage ALU result).
- de_ready  in  1  decode accepts the head entry (hazard-unit stall enable).
- de_valid  out  1  head entry is valid.
- de_inst  out  32  head instruction; 32'h0000_0013 (NOP) when de_valid is 0.
- de_pc  out  32  head PC; 0 when de_valid is 0.
- de_pcinc  out  32  de_pc + 4; 0 when de_valid is 0.

## Operation

- State machine has three states:
  - IDLE: no fetch in flight.
  - WAIT: fetch in flight, result will be kept.
  - DROP: fetch in flight, result will be discarded.
- imem_req = (state != IDLE).
- imem_addr is a register loaded at issue.
- Issue rule: in IDLE, when count < DEPTH and redirect = 0:
  - load imem_addr <= fetch_pc;
  - fetch_pc <= fetch_pc + 4, wrapping modulo 2^32;
  - go to WAIT.
- WAIT:
  - on imem_ack, push {imem_addr, imem_rdata, imem_addr + 4} and go to IDLE;
  - on redirect without ack, go to DROP.
- DROP:
  - on imem_ack, discard the data and go to IDLE;
  - imem_req stays high until ack, because an outstanding request is never abandoned.
- Redirect, in any state: fetch_pc <= redirect_pc. The queue is flushed: count, read pointer and write pointer all go to 0.
- Redirect in WAIT coinciding with imem_ack: the data is discarded and the state goes to IDLE.
- Redirect in DROP: fetch_pc is updated and the state stays DROP.
- Pop occurs when de_valid && de_ready && !redirect.
- Push occurs on a kept ack.
- Push and pop in the same cycle leave count unchanged.
- Overflow is impossible, because at most one fetch is outstanding and issue requires count < DEPTH. The bench asserts this anyway.
- de_valid = (count != 0).
- de_* outputs are combinational from the head entry, masked to NOP/0 when the queue is empty.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally. count is $clog2(DEPTH+1) bits wide.

## Timing

- Reset values:
  - state IDLE, fetch_pc RESET_PC, imem_addr RESET_PC, count 0;
  - imem_req 0;
  - de_valid 0, de_inst NOP, de_pc 0, de_pcinc 0.
- First imem_req rises in the first clock edge after rst_n deasserts.
- Fetch latency:
  - issue at edge N;
  - ack in cycle N+k, with k ≥ 1;
  - entry visible on de_* in cycle N+k+1 when the queue was empty.
- Issue back-to-back with zero-wait memory (ack always in the first request cycle): one instruction every 2 cycles (IDLE, WAIT).
- Redirect asserted in cycle R:
  - de_valid is 0 from cycle R+1;
  - first request to redirect_pc is at edge R+1, or 1 edge after the drained DROP ack.
- rst_n asserted mid-fetch: all state returns to reset values immediately. A late imem_ack after reset is ignored because the state is IDLE.

## Structure

- fetch_pkg holds:
  - NOP_INST = 32'h0000_0013;
  - the state enum typedef {IDLE, WAIT, DROP};
  - a fetch_entry_t struct holding pc, inst and pcinc.
- One sub-module, fetch_fifo: a synchronous FIFO of fetch_entry_t with push, pop, flush, count and head output, parameterised by DEPTH.
- The control FSM and fetch PC live in fetch_queue.

## Test plan

- Reset, then ack every request after 1 cycle, de_ready = 1 -> de_pc sequence 0, 4, 8, 12; de_inst matches memory image; first de_valid appears 3 cycles after reset release.
- de_ready = 0 with DEPTH = 4 -> exactly 4 requests issued, then imem_req stays 0; on releasing de_ready, entries drain in order 0, 4, 8, 12.
- Redirect to 0x100 while in WAIT with ack delayed 3 cycles -> acked data dropped; de_valid is 0 next cycle; next imem_addr is 0x100 and de_pc is 0x100, de_pcinc is 0x104.
- Redirect to 0x40 in the same cycle as imem_ack -> data discarded; next request addr is 0x40; no entry pushed.
- Simultaneous push and pop at count 2 -> count stays 2 and order is preserved; fetch_pc wraps correctly after a redirect to 0xFFFF_FFFC.
- rst_n pulsed low while in WAIT, with ack arriving 1 cycle after release -> ack ignored; the first fetch after reset is RESET_PC; all outputs at reset values during reset.
